// File: rtl/i2c_edid_responder_if.sv
// i2c_edid_responder_if
// Pad-side DDC bus seen by the EDID responder.
//   scl_in : raw SCL pad level (asynchronous to clk)
//   sda_in : raw SDA pad level (asynchronous to clk)
//   sda_oe : 1 = pull SDA low, 0 = release (open-drain, tristate lives in the pad ring)
// Signalling contract: there is no valid/ready pair on this bus. The master owns SCL.
// The wired-AND SDA level is sampled by the target on SCL rise. The target changes
// sda_oe only while SCL is low, and only after its data hold time. The single exception
// is releasing SDA when a START or STOP is seen.
interface i2c_edid_responder_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_edid_responder.sv
// i2c_edid_responder
// DDC/I2C target that answers as a 256-byte EDID EEPROM. Byte contents come from an
// external synchronous ROM with one clock of read latency.
// Ports:
//   clk, rst      : system clock (>= 20x SCL) and synchronous active-high reset
//   bus           : SCL/SDA pad levels in, SDA open-drain enable out
//   edid_addr     : byte offset into the ROM (the internal offset pointer)
//   edid_data     : ROM byte, valid one clk after edid_addr changes
//   busy          : high from the address-match ACK until STOP or re-START
//   rd_byte_done  : one-clk pulse when the master ACKs or NACKs a byte we sent
//   dbg_state     : current FSM state encoding
module i2c_edid_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         FILTER_LEN  = 4,
  parameter int         HOLD_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_edid_responder_if.slave   bus,
  output logic [7:0]            edid_addr,
  input  logic [7:0]            edid_data,
  output logic                  busy,
  output logic                  rd_byte_done,
  output logic [3:0]            dbg_state
);

  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int HW = $clog2(HOLD_CYCLES) + 1;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ADDR       = 4'd1,
    ST_ADDR_ACK   = 4'd2,
    ST_WR_OFFSET  = 4'd3,
    ST_WR_ACK     = 4'd4,
    ST_WR_DISCARD = 4'd5,
    ST_RD_DATA    = 4'd6,
    ST_RD_ACK     = 4'd7,
    ST_IGNORE     = 4'd8
  } state_t;

  // Input conditioning
  logic [1:0]    scl_s, sda_s;
  logic          scl_f, sda_f;
  logic          scl_d, sda_d;
  logic [FW-1:0] scl_cnt, sda_cnt;

  // A filtered level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s   <= 2'b11;
      sda_s   <= 2'b11;
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_d   <= 1'b1;
      sda_d   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      scl_s <= {scl_s[0], bus.scl_in};
      sda_s <= {sda_s[0], bus.sda_in};
      scl_d <= scl_f;
      sda_d <= sda_f;
      if (scl_s[1] == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_s[1];
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + FW'(1);
      end
      if (sda_s[1] == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_s[1];
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + FW'(1);
      end
    end
  end

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign sda_rise = sda_f & ~sda_d;
  assign sda_fall = ~sda_f & sda_d;
  // START/STOP need SCL steadily high; an SDA edge in the same clk as an SCL edge is data.
  assign start_det = sda_fall & scl_f & scl_d;
  assign stop_det  = sda_rise & scl_f & scl_d;

  // Hold timer: hold_fire is high in the clk whose closing edge lands exactly
  // HOLD_CYCLES clk after the edge that made scl_f low.
  logic [HW-1:0] hold_cnt;
  logic          hold_fire;
  assign hold_fire = (hold_cnt == HW'(1));

  always_ff @(posedge clk) begin
    if (rst || scl_rise || start_det || stop_det) begin
      hold_cnt <= '0;
    end else if (scl_fall) begin
      hold_cnt <= HW'(HOLD_CYCLES - 1);
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
    end
  end

  // FSM and datapath
  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] ptr, ptr_n;
  logic       sda_oe_q, oe_n;
  logic       busy_n, done_n;
  // ack_phase: in an ACK state, set once the 9th rise has passed, so the next
  // hold_fire ends the ACK slot instead of starting it.
  logic       ack_phase, ack_phase_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      ptr          <= '0;
      sda_oe_q     <= 1'b0;
      busy         <= 1'b0;
      rd_byte_done <= 1'b0;
      ack_phase    <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      shift        <= shift_n;
      ptr          <= ptr_n;
      sda_oe_q     <= oe_n;
      busy         <= busy_n;
      rd_byte_done <= done_n;
      ack_phase    <= ack_phase_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    ptr_n       = ptr;
    oe_n        = sda_oe_q;
    busy_n      = busy;
    done_n      = 1'b0;
    ack_phase_n = ack_phase;
    if (start_det) begin
      state_n     = ST_ADDR;
      bit_cnt_n   = '0;
      oe_n        = 1'b0;
      busy_n      = 1'b0;
      ack_phase_n = 1'b0;
    end else if (stop_det) begin
      state_n     = ST_IDLE;
      bit_cnt_n   = '0;
      oe_n        = 1'b0;
      busy_n      = 1'b0;
      ack_phase_n = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              ack_phase_n = 1'b0;
              state_n     = (shift[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise) begin
            ack_phase_n = 1'b1;
          end else if (hold_fire) begin
            if (!ack_phase) begin
              oe_n   = 1'b1;
              busy_n = 1'b1;
            end else begin
              ack_phase_n = 1'b0;
              bit_cnt_n   = '0;
              // shift[0] still holds the R/W bit of the address byte.
              if (shift[0]) begin
                shift_n = edid_data;
                oe_n    = ~edid_data[7];
                state_n = ST_RD_DATA;
              end else begin
                oe_n    = 1'b0;
                state_n = ST_WR_OFFSET;
              end
            end
          end
        end
        ST_WR_OFFSET, ST_WR_DISCARD: begin
          if (scl_rise) begin
            shift_n   = {shift[6:0], sda_f};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              if (state == ST_WR_OFFSET) ptr_n = {shift[6:0], sda_f};
              ack_phase_n = 1'b0;
              state_n     = ST_WR_ACK;
            end
          end
        end
        ST_WR_ACK: begin
          if (scl_rise) begin
            ack_phase_n = 1'b1;
          end else if (hold_fire) begin
            if (!ack_phase) begin
              oe_n = 1'b1;
            end else begin
              oe_n        = 1'b0;
              ack_phase_n = 1'b0;
              bit_cnt_n   = '0;
              state_n     = ST_WR_DISCARD;
            end
          end
        end
        ST_RD_DATA: begin
          // shift[7] always holds the bit to present after the next SCL fall.
          if (scl_rise) begin
            shift_n   = {shift[6:0], 1'b0};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) ptr_n = ptr + 8'd1;
          end else if (hold_fire) begin
            if (bit_cnt == 4'd8) begin
              oe_n        = 1'b0;
              ack_phase_n = 1'b0;
              state_n     = ST_RD_ACK;
            end else begin
              oe_n = ~shift[7];
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            done_n = 1'b1;
            if (sda_f) state_n = ST_IGNORE;
            else       ack_phase_n = 1'b1;
          end else if (hold_fire && ack_phase) begin
            // ptr moved at the 8th rise, so edid_data already reflects the new offset.
            shift_n     = edid_data;
            oe_n        = ~edid_data[7];
            bit_cnt_n   = '0;
            ack_phase_n = 1'b0;
            state_n     = ST_RD_DATA;
          end
        end
        ST_IDLE, ST_IGNORE: begin
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign bus.sda_oe = sda_oe_q;
  assign edid_addr  = ptr;
  assign dbg_state  = state;

endmodule
